// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encoding and default sizing for timer_ctrl
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int TICK_DIV_DEF = 50000000;
    localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// rtl/timer_ctrl_tick_gen.sv - prescaler with enable, synchronous zero and registered wrap pulse
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_en,
    input  logic i_zero,
    output logic o_at_wrap,
    output logic o_tick
);

    localparam int            W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    // Combinational wrap flag lets the FSM step the count on the same edge the tick is registered.
    assign o_at_wrap = (r_cnt == LAST);
    assign o_tick    = r_tick;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_zero) begin
                r_cnt <= '0;
            end else if (i_en) begin
                if (o_at_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - start/pause/clear countdown timer stepped by a prescaled tick enable
// Optional feature: TIMER_CTRL_AUTORELOAD_EN reloads the start value on the final tick.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             done
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             r_running;
    logic             r_done, w_done_next;
    logic             w_en, w_zero, w_at_wrap;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    logic [CNT_W-1:0] r_load, w_load_next;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_in    (clk_in),
        .rst       (rst),
        .i_en      (w_en),
        .i_zero    (w_zero),
        .o_at_wrap (w_at_wrap),
        .o_tick    (tick)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            r_load    <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_running <= (w_state_next == ST_RUN);
            r_done    <= w_done_next;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            r_load    <= w_load_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_done_next  = 1'b0;
        w_en         = 1'b0;
        w_zero       = 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
        w_load_next  = r_load;
`endif
        if (clear) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_zero       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_zero = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                        w_load_next = load_val;
`endif
                        if (load_val == '0) begin
                            w_state_next = ST_DONE;
                            w_count_next = '0;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next = ST_RUN;
                            w_count_next = load_val;
                        end
                    end
                end
                default: begin
                    // RUN and PAUSE share the step path: the resuming edge counts like any RUN edge.
                    if (pause) begin
                        w_state_next = ST_PAUSE;
                    end else begin
                        w_state_next = ST_RUN;
                        w_en         = 1'b1;
                        if (w_at_wrap && (r_count != '0)) begin
                            if (r_count == CNT_W'(1)) begin
                                w_done_next = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                                w_count_next = r_load;
`else
                                w_count_next = '0;
                                w_state_next = ST_DONE;
`endif
                            end else begin
                                w_count_next = r_count - 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign done    = r_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl with TICK_DIV=4
module tb_timer_ctrl;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       pause  = 1'b0;
    logic       clear  = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] count;
    logic       running;
    logic       tick;
    logic       done;

    int checks   = 0;
    int failures = 0;

    timer_ctrl #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .load_val (load_val),
        .count    (count),
        .running  (running),
        .tick     (tick),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_cnt, input logic e_run,
                           input logic e_tick, input logic e_done);
        chk({tag, "_count"},   32'(count),   32'(e_cnt));
        chk({tag, "_running"}, 32'(running), 32'(e_run));
        chk({tag, "_tick"},    32'(tick),    32'(e_tick));
        chk({tag, "_done"},    32'(done),    32'(e_done));
    endtask

    task automatic start_with(input logic [7:0] v);
        start    = 1'b1;
        load_val = v;
        @(negedge clk_in);
        start    = 1'b0;
        load_val = 8'hAA;
    endtask

    // load 3, no pause: ticks after E0+4, +8, +12
    task automatic run_basic(input string tag);
        logic [7:0] e_cnt;
        start_with(8'd3);
        chk_all({tag, "_e0"}, 8'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            e_cnt = (k < 4) ? 8'd3 : (k < 8) ? 8'd2 : (k < 12) ? 8'd1 : 8'd0;
            chk_all($sformatf("%s_k%0d", tag, k), e_cnt, (k < 12), (k % 4 == 0), (k == 12));
        end
        @(negedge clk_in);
        chk_all({tag, "_hold"}, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e_cnt;
        logic       p;

        #2;
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        chk_all("idle", 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_CTRL_AUTORELOAD_EN
        start_with(8'd2);
        chk_all("ar_e0", 8'd2, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk_in);
            e_cnt = ((k % 8) < 4) ? 8'd2 : 8'd1;
            chk_all($sformatf("ar_k%0d", k), e_cnt, 1'b1, (k % 4 == 0), (k == 8 || k == 16));
        end
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        chk_all("ar_clear", 8'd0, 1'b0, 1'b0, 1'b0);
`else
        run_basic("basic");

        // pause high at edges E0+2..E0+6: ticks at E0+9, 13, 17
        start_with(8'd3);
        chk_all("pause_e0", 8'd3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            p     = (k >= 2 && k <= 6);
            pause = p;
            @(negedge clk_in);
            e_cnt = (k < 9) ? 8'd3 : (k < 13) ? 8'd2 : (k < 17) ? 8'd1 : 8'd0;
            chk_all($sformatf("pause_k%0d", k), e_cnt, (!p && k < 17),
                    (k == 9 || k == 13 || k == 17), (k == 17));
        end
        pause = 1'b0;

        // clear at E0+6, then a fresh start ticks exactly 4 edges later
        start_with(8'd3);
        for (int k = 1; k <= 6; k++) begin
            clear = (k == 6);
            @(negedge clk_in);
        end
        clear = 1'b0;
        chk_all("clear_e6", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        chk_all("clear_idle", 8'd0, 1'b0, 1'b0, 1'b0);
        start_with(8'd2);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            chk_all($sformatf("restart_k%0d", k), (k < 4) ? 8'd2 : 8'd1, 1'b1, (k == 4), 1'b0);
        end
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;

        // start during RUN is ignored; async reset at E0+5 clears outputs before the next edge
        start_with(8'd3);
        for (int k = 1; k <= 5; k++) begin
            start    = (k == 2);
            load_val = 8'd9;
            @(negedge clk_in);
        end
        start = 1'b0;
        chk("ign_start_count", 32'(count), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        run_basic("post_rst");
`endif

        // load_val = 0 goes straight to DONE with a single done pulse
        start_with(8'd0);
        chk_all("zero_e0", 8'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_in);
        chk_all("zero_e1", 8'd0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
